// File: rtl/udp_mon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_mon_pkg : shared types and constants for the UDP command monitor      |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
package udp_mon_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ARMED   = 3'd1,
    ST_WR_REQ  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WAIT = 3'd5
  } mon_state_e;

  localparam logic [7:0] CMD_NEW          = 8'h01;
  localparam logic [7:0] CMD_RESEND_ALL   = 8'h02;
  localparam logic [7:0] CMD_RESEND_ONE   = 8'h03;
  localparam logic [7:0] CMD_RESEND_RANGE = 8'h05;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BUSY    = 3'd1;
  localparam logic [2:0] ERR_UNKNOWN = 3'd2;
  localparam logic [2:0] ERR_RANGE   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/udp_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_sync2 : two-flop synchroniser exposing both stages                   |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module udp_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] s1,
  output logic [W-1:0] s2
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s1 = s1_q;
  assign s2 = s2_q;

endmodule
`default_nettype wire

// File: rtl/udp_cmd_monitor_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_cmd_monitor_p : NIOS command decoder driving SDRAM windows/packetiser |
// | Option macro      : TIMEOUT_EN (watchdog in WR_REQ / RD_WAIT)             |
// | Revision          : 1.0 - initial parametrised release                   |
// +--------------------------------------------------------------------------+
module udp_cmd_monitor_p
  import udp_mon_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 32,
  parameter int WORD_SHIFT  = 2,
  parameter int SETTLE_CYC  = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              begin_work,
  input  logic [7:0]        flag,
  input  logic [ADDR_W-1:0] frame_step,
  input  logic [ADDR_W-1:0] frame_addr_now,
  input  logic [ADDR_W-1:0] frame_addr_begin,
  input  logic [ADDR_W-1:0] frame_addr_end,
  input  logic              busy,
  input  logic              sdram_wr_done,
  input  logic              sdram_rd_done,
  input  logic              err_clr,
  output logic              sdram_wr,
  output logic              sdram_rd,
  output logic [ADDR_W-1:0] wraddr_begin,
  output logic [ADDR_W-1:0] wraddr_end,
  output logic [ADDR_W-1:0] rdaddr_begin,
  output logic [ADDR_W-1:0] rdaddr_end,
  output logic              packet_start,
  output logic [CNT_W-1:0]  cnt_init,
  output logic [ADDR_W-1:0] frame_length,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  logic       begin_work_s2, wr_done_s2, rd_done_s2;
  logic [7:0] flag_s1, flag_s2;
  logic [2:0] sync_s1_unused;

  udp_sync2 #(.W(1)) u_sync_bw   (.clk(clk), .rst(RST), .d(begin_work),    .s1(sync_s1_unused[0]), .s2(begin_work_s2));
  udp_sync2 #(.W(8)) u_sync_flag (.clk(clk), .rst(RST), .d(flag),          .s1(flag_s1),           .s2(flag_s2));
  udp_sync2 #(.W(1)) u_sync_wr   (.clk(clk), .rst(RST), .d(sdram_wr_done), .s1(sync_s1_unused[1]), .s2(wr_done_s2));
  udp_sync2 #(.W(1)) u_sync_rd   (.clk(clk), .rst(RST), .d(sdram_rd_done), .s1(sync_s1_unused[2]), .s2(rd_done_s2));

  mon_state_e        state_q, state_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [ADDR_W-1:0] wr_b_q, wr_b_d, wr_e_q, wr_e_d;
  logic [ADDR_W-1:0] rd_b_q, rd_b_d, rd_e_q, rd_e_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [2:0]        code_q, code_d;

  logic              flag_ev, to_hit, new_err;
  logic [2:0]        new_code;
  logic              ld_new, ld_all, ld_one, ld_range;
  logic [ADDR_W-1:0] step_w, now_w, beg_w, end_w;

  assign flag_ev = (flag_s1 != flag_s2);
  assign step_w  = frame_step       >> WORD_SHIFT;
  assign now_w   = frame_addr_now   >> WORD_SHIFT;
  assign beg_w   = frame_addr_begin >> WORD_SHIFT;
  assign end_w   = frame_addr_end   >> WORD_SHIFT;

`ifdef TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counter restarts on every entry into a waiting state since other states hold it at zero.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_WR_REQ || state_q == ST_RD_WAIT) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (RST) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign to_hit = (to_cnt_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (RST) state_q <= ST_OFF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    new_err  = 1'b0;
    new_code = ERR_NONE;
    ld_new   = 1'b0;
    ld_all   = 1'b0;
    ld_one   = 1'b0;
    ld_range = 1'b0;
    case (state_q)
      ST_OFF: if (begin_work_s2) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!begin_work_s2) begin
          state_d = ST_OFF;
        end else if (flag_ev && !busy) begin
          case (flag_s1)
            CMD_NEW:        begin ld_new = 1'b1; state_d = ST_WR_REQ; end
            CMD_RESEND_ALL: begin ld_all = 1'b1; state_d = ST_RD_REQ; end
            CMD_RESEND_ONE: begin ld_one = 1'b1; state_d = ST_RD_REQ; end
            CMD_RESEND_RANGE: begin
              if (frame_addr_end < frame_addr_begin) begin
                new_err  = 1'b1;
                new_code = ERR_RANGE;
              end else begin
                ld_range = 1'b1;
                state_d  = ST_RD_REQ;
              end
            end
            default: begin new_err = 1'b1; new_code = ERR_UNKNOWN; end
          endcase
        end
      end
      ST_WR_REQ: begin
        if (wr_done_s2) state_d = ST_SETTLE;
        else if (to_hit) begin state_d = ST_ARMED; new_err = 1'b1; new_code = ERR_TIMEOUT; end
      end
      ST_SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = ST_RD_REQ;
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (rd_done_s2) state_d = begin_work_s2 ? ST_ARMED : ST_OFF;
        else if (to_hit) begin state_d = ST_ARMED; new_err = 1'b1; new_code = ERR_TIMEOUT; end
      end
      default: state_d = ST_OFF;
    endcase
    // Any command that cannot be taken right now is a collision.
    if (flag_ev && (state_q != ST_ARMED || busy || !begin_work_s2)) begin
      new_err  = 1'b1;
      new_code = ERR_BUSY;
    end
  end

  always_comb begin
    sdram_wr     = (state_q == ST_WR_REQ);
    sdram_rd     = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
    packet_start = (state_q == ST_RD_REQ);
  end

  always_comb begin
    wr_b_d = wr_b_q;
    wr_e_d = wr_e_q;
    rd_b_d = rd_b_q;
    rd_e_d = rd_e_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if (ld_new) begin
      wr_b_d = '0;
      wr_e_d = step_w;
    end
    if (ld_new || ld_all) begin
      rd_b_d = '0;
      rd_e_d = step_w;
      len_d  = frame_step;
      cnt_d  = '0;
    end
    if (ld_one) begin
      rd_b_d = now_w;
      rd_e_d = now_w + ADDR_W'(1);
      len_d  = ADDR_W'(1) << WORD_SHIFT;
      cnt_d  = CNT_W'(frame_addr_now);
    end
    if (ld_range) begin
      rd_b_d = beg_w;
      rd_e_d = end_w;
      len_d  = frame_addr_end - frame_addr_begin;
      cnt_d  = CNT_W'(beg_w);
    end
    settle_cnt_d = (state_q == ST_SETTLE) ? settle_cnt_q + SET_W'(1) : '0;
    err_d  = err_q;
    code_d = code_q;
    if (err_clr) begin
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end
    if (new_err && (!err_q || err_clr)) begin
      err_d  = 1'b1;
      code_d = new_code;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      settle_cnt_q <= '0;
      wr_b_q <= '0;
      wr_e_q <= '0;
      rd_b_q <= '0;
      rd_e_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      settle_cnt_q <= settle_cnt_d;
      wr_b_q <= wr_b_d;
      wr_e_q <= wr_e_d;
      rd_b_q <= rd_b_d;
      rd_e_q <= rd_e_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign wraddr_begin = wr_b_q;
  assign wraddr_end   = wr_e_q;
  assign rdaddr_begin = rd_b_q;
  assign rdaddr_end   = rd_e_q;
  assign frame_length = len_q;
  assign cnt_init     = cnt_q;
  assign err          = err_q;
  assign err_code     = code_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_cmd_monitor_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_udp_cmd_monitor_p : directed bench for udp_cmd_monitor_p              |
// | Option macro         : TIMEOUT_EN selects the watchdog scenario          |
// | Revision             : 1.0 - initial release                             |
// +--------------------------------------------------------------------------+
module tb_udp_cmd_monitor_p;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        begin_work = 1'b0;
  logic [7:0]  flag = 8'h00;
  logic [15:0] frame_step = '0, frame_addr_now = '0, frame_addr_begin = '0, frame_addr_end = '0;
  logic        busy = 1'b0, sdram_wr_done = 1'b0, sdram_rd_done = 1'b0, err_clr = 1'b0;
  logic        sdram_wr, sdram_rd, packet_start, err;
  logic [15:0] wraddr_begin, wraddr_end, rdaddr_begin, rdaddr_end, frame_length;
  logic [31:0] cnt_init;
  logic [2:0]  err_code;

  int n_vec = 0;
  int n_miscmp = 0;
  int ps_count = 0;
  int n, ps0;

  udp_cmd_monitor_p #(
    .ADDR_W(16), .CNT_W(32), .WORD_SHIFT(2), .SETTLE_CYC(10), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .RST(RST), .begin_work(begin_work), .flag(flag),
    .frame_step(frame_step), .frame_addr_now(frame_addr_now),
    .frame_addr_begin(frame_addr_begin), .frame_addr_end(frame_addr_end),
    .busy(busy), .sdram_wr_done(sdram_wr_done), .sdram_rd_done(sdram_rd_done),
    .err_clr(err_clr), .sdram_wr(sdram_wr), .sdram_rd(sdram_rd),
    .wraddr_begin(wraddr_begin), .wraddr_end(wraddr_end),
    .rdaddr_begin(rdaddr_begin), .rdaddr_end(rdaddr_end),
    .packet_start(packet_start), .cnt_init(cnt_init), .frame_length(frame_length),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (packet_start) ps_count++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return sdram_wr;
      1:       return sdram_rd;
      default: return packet_start;
    endcase
  endfunction

  // Returns the number of negedges until the selected output reaches lvl, or -1.
  task automatic wait_sig(input int sel, input logic lvl, input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (pick(sel) == lvl) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic finish_read(input string tag);
    int k;
    sdram_rd_done = 1'b1;
    wait_sig(1, 1'b0, 10, k);
    chk(tag, k, 3);
    sdram_rd_done = 1'b0;
    cyc(3);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    cyc(3);
    chk("rst_wr", sdram_wr, 0);
    chk("rst_rd", sdram_rd, 0);
    chk("rst_ps", packet_start, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_wr_end", wraddr_end, 0);
    RST = 1'b0;
    begin_work = 1'b1;
    cyc(4);

    // New frame: write, settle, send.
    frame_step = 16'h0100;
    flag = 8'h01;
    wait_sig(0, 1'b1, 10, n);
    chk("new_wr_lat", n, 2);
    chk("new_wr_b", wraddr_begin, 16'h0000);
    chk("new_wr_e", wraddr_end, 16'h0040);
    chk("new_rd_e", rdaddr_end, 16'h0040);
    chk("new_len", frame_length, 16'h0100);
    chk("new_cnt", cnt_init, 0);
    cyc(3);
    chk("new_wr_hold", {sdram_wr, sdram_rd, packet_start}, 3'b100);
    sdram_wr_done = 1'b1;
    wait_sig(0, 1'b0, 10, n);
    chk("new_wr_drop", n, 3);
    sdram_wr_done = 1'b0;
    wait_sig(2, 1'b1, 30, n);
    chk("new_settle", n, 10);
    chk("new_rd_req", sdram_rd, 1);
    cyc(1);
    chk("new_ps_pulse", {packet_start, sdram_rd}, 2'b01);
    chk("new_ps_cnt", ps_count, 1);
    finish_read("new_rd_drop");

    // Single-frame resend near a word boundary.
    frame_addr_now = 16'h0FFC;
    flag = 8'h03;
    wait_sig(1, 1'b1, 10, n);
    chk("one_lat", n, 2);
    chk("one_rd_b", rdaddr_begin, 16'h03FF);
    chk("one_rd_e", rdaddr_end, 16'h0400);
    chk("one_len", frame_length, 16'h0004);
    chk("one_cnt", cnt_init, 32'h0000_0FFC);
    chk("one_no_wr", sdram_wr, 0);
    chk("one_wr_hold", wraddr_end, 16'h0040);
    finish_read("one_rd_drop");

    // Inverted range is rejected.
    frame_addr_begin = 16'h0020;
    frame_addr_end   = 16'h0010;
    flag = 8'h05;
    cyc(5);
    chk("badrng_err", {err, err_code}, {1'b1, 3'd3});
    chk("badrng_norq", {sdram_rd, sdram_wr}, 0);
    chk("badrng_hold", rdaddr_begin, 16'h03FF);
    clear_err();
    chk("clr_err", {err, err_code}, 0);

    // Command arriving mid-read is a collision.
    ps0 = ps_count;
    flag = 8'h02;
    wait_sig(1, 1'b1, 10, n);
    chk("col_lat", n, 2);
    cyc(2);
    flag = 8'h04;
    cyc(4);
    chk("col_err", {err, err_code}, {1'b1, 3'd1});
    chk("col_rd_hold", sdram_rd, 1);
    finish_read("col_rd_drop");
    chk("col_ps_once", ps_count, ps0 + 1);
    clear_err();

    // Unknown code ignored, then a resend-all is accepted.
    flag = 8'h07;
    cyc(5);
    chk("unk_err", {err, err_code}, {1'b1, 3'd2});
    chk("unk_idle", {sdram_rd, sdram_wr}, 0);
    clear_err();
    frame_step = 16'h0200;
    flag = 8'h02;
    wait_sig(1, 1'b1, 10, n);
    chk("all_lat", n, 2);
    chk("all_rd_b", rdaddr_begin, 16'h0000);
    chk("all_rd_e", rdaddr_end, 16'h0080);
    chk("all_len", frame_length, 16'h0200);
    chk("all_err", err, 0);
    finish_read("all_rd_drop");

    // Valid range resend.
    frame_addr_begin = 16'h0040;
    frame_addr_end   = 16'h0100;
    flag = 8'h05;
    wait_sig(1, 1'b1, 10, n);
    chk("rng_lat", n, 2);
    chk("rng_rd_b", rdaddr_begin, 16'h0010);
    chk("rng_rd_e", rdaddr_end, 16'h0040);
    chk("rng_len", frame_length, 16'h00C0);
    chk("rng_cnt", cnt_init, 32'h10);
    finish_read("rng_rd_drop");

    flag = 8'h02;
    wait_sig(1, 1'b1, 10, n);
    chk("to_lat", n, 2);
`ifdef TIMEOUT_EN
    // One request cycle plus the full watchdog window in RD_WAIT.
    wait_sig(1, 1'b0, 200, n);
    chk("to_rd_len", n, 101);
    chk("to_err", {err, err_code}, {1'b1, 3'd4});
    clear_err();
    flag = 8'h03;
    wait_sig(1, 1'b1, 10, n);
    chk("to_next_cmd", n, 2);
    finish_read("to_next_drop");
`else
    wait_sig(1, 1'b0, 150, n);
    chk("nto_rd_hold", n, -1);
    chk("nto_err", err, 0);
    finish_read("nto_rd_drop");
`endif

    // Reset during a write aborts everything.
    flag = 8'h01;
    wait_sig(0, 1'b1, 10, n);
    chk("mid_wr_lat", n, 2);
    RST = 1'b1;
    cyc(1);
    chk("mid_rst_out", {sdram_wr, sdram_rd, packet_start}, 0);
    chk("mid_rst_addr", {wraddr_end, rdaddr_end, frame_length}, 0);
    chk("mid_rst_err", {err, err_code}, 0);
    RST = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
